// File: rtl/iddmm_pkg.sv
// Shared IDDMM definitions: default operand width, the multiplier tag record
// that travels alongside each product, and the round-robin pick helper.
package iddmm_pkg;

    localparam int IDDMM_WIDTH   = 128;
    // Upper bound on requesters sharing one multiplier; sizes the tag id field.
    localparam int IDDMM_MAX_REQ = 16;
    localparam int IDDMM_ID_W    = $clog2(IDDMM_MAX_REQ);

    typedef struct packed {
        logic                  vld;
        logic                  lo;
        logic [IDDMM_ID_W-1:0] id;
    } mul_tag_t;

    // One-hot grant for the first valid requester at or above ptr, wrapping
    // modulo num_req. ptr must be below num_req; bits at or above num_req are
    // ignored and never granted.
    function automatic logic [IDDMM_MAX_REQ-1:0] rr_pick(
        input logic [IDDMM_MAX_REQ-1:0] valid,
        input logic [IDDMM_ID_W-1:0]    ptr,
        input int                       num_req
    );
        logic [IDDMM_MAX_REQ-1:0] gnt;
        logic                     found;
        int                       idx;
        logic [IDDMM_ID_W-1:0]    idx_w;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < IDDMM_MAX_REQ; i++) begin
            if (i < num_req) begin
                idx = int'(ptr) + i;
                if (idx >= num_req) begin
                    idx = idx - num_req;
                end else begin
                    idx = idx;
                end
                idx_w = IDDMM_ID_W'(idx);
                if (!found && valid[idx_w]) begin
                    gnt[idx_w] = 1'b1;
                    found      = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/iddmm_tag_pipe.sv
// Fixed-depth shift register of multiplier tags. Stage 0 takes the tag of the
// operands just registered; the last stage lines up with the matching product.
module iddmm_tag_pipe
    import iddmm_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     clr_i,
    input  mul_tag_t tag_i,
    output mul_tag_t tag_o,
    output logic     any_valid_o
);

    mul_tag_t stage_q [DEPTH];

    // Shift tags one stage per cycle; clear drops every tag in flight.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    // Any stage holding a live tag means a product is still owed.
    always_comb begin
        any_valid_o = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            any_valid_o = any_valid_o | stage_q[k].vld;
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/iddmm_mul_arbiter.sv
// Round-robin front end for one shared, fully pipelined multiplier. Accepts at
// most one operand pair per cycle, registers it onto the multiplier inputs,
// tracks who asked through a latency-matched tag pipe and returns the product
// on a shared response bus flagged by a one-hot valid.
module iddmm_mul_arbiter
    import iddmm_pkg::*;
#(
    parameter int WIDTH       = IDDMM_WIDTH,
    parameter int NUM_REQ     = 4,   // 2 .. IDDMM_MAX_REQ
    parameter int MUL_LATENCY = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0]       req_lo,
    input  logic [NUM_REQ*WIDTH-1:0] req_x,
    input  logic [NUM_REQ*WIDTH-1:0] req_y,
    output logic [WIDTH-1:0]         mul_x,
    output logic [WIDTH-1:0]         mul_y,
    input  logic [2*WIDTH-1:0]       mul_result,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     busy
);

    // Operands land one cycle after the handshake and the product MUL_LATENCY
    // cycles later, so the tag must ride MUL_LATENCY+1 stages.
    localparam int                    DEPTH    = MUL_LATENCY + 1;
    localparam logic [IDDMM_ID_W-1:0] LAST_ID  = IDDMM_ID_W'(NUM_REQ - 1);
    localparam logic [IDDMM_ID_W-1:0] ID_ONE   = IDDMM_ID_W'(1);
    localparam logic [NUM_REQ-1:0]    ONE_HOT0 = NUM_REQ'(1);

    logic [IDDMM_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]      mul_x_q, mul_x_d;
    logic [WIDTH-1:0]      mul_y_q, mul_y_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0]    rsp_result_q, rsp_result_d;

    logic [NUM_REQ-1:0]    grant_s;
    logic                  hs_s;
    logic [IDDMM_ID_W-1:0] gnt_id_s;
    logic [WIDTH-1:0]      sel_x_s;
    logic [WIDTH-1:0]      sel_y_s;
    logic                  sel_lo_s;
    mul_tag_t              tag_in_s;
    mul_tag_t              tag_out_s;
    logic                  tag_any_s;

    assign grant_s   = NUM_REQ'(rr_pick(IDDMM_MAX_REQ'(req_valid), rr_ptr_q, NUM_REQ));
    assign hs_s      = |grant_s;
    assign req_ready = grant_s;

    // AND-OR mux of the granted requester's operands, mode and index.
    always_comb begin
        gnt_id_s = '0;
        sel_x_s  = '0;
        sel_y_s  = '0;
        sel_lo_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_id_s = gnt_id_s | (grant_s[i] ? IDDMM_ID_W'(i) : '0);
            sel_x_s  = sel_x_s | (req_x[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
            sel_y_s  = sel_y_s | (req_y[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
            sel_lo_s = sel_lo_s | (req_lo[i] & grant_s[i]);
        end
    end

    // Accept path: load operands, launch a tag and move the pointer past the winner.
    always_comb begin
        mul_x_d  = mul_x_q;
        mul_y_d  = mul_y_q;
        rr_ptr_d = rr_ptr_q;
        tag_in_s = '0;
        if (hs_s) begin
            mul_x_d      = sel_x_s;
            mul_y_d      = sel_y_s;
            tag_in_s.vld = 1'b1;
            tag_in_s.lo  = sel_lo_s;
            tag_in_s.id  = gnt_id_s;
            rr_ptr_d     = (gnt_id_s == LAST_ID) ? '0 : (gnt_id_s + ID_ONE);
        end else begin
            mul_x_d  = mul_x_q;
            mul_y_d  = mul_y_q;
            rr_ptr_d = rr_ptr_q;
            tag_in_s = '0;
        end
    end

    // Response path: flag the owner of the emerging product; idle cycles keep the old data.
    always_comb begin
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        if (tag_out_s.vld) begin
            rsp_valid_d  = ONE_HOT0 << tag_out_s.id;
            rsp_result_d = tag_out_s.lo ? {{WIDTH{1'b0}}, mul_result[WIDTH-1:0]} : mul_result;
        end else begin
            rsp_valid_d  = '0;
            rsp_result_d = rsp_result_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            mul_x_q      <= '0;
            mul_y_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            mul_x_q      <= mul_x_d;
            mul_y_q      <= mul_y_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    iddmm_tag_pipe #(
        .DEPTH (DEPTH)
    ) u_tag_pipe (
        .clk         (clk),
        .clr_i       (!rst_n),
        .tag_i       (tag_in_s),
        .tag_o       (tag_out_s),
        .any_valid_o (tag_any_s)
    );

    assign mul_x      = mul_x_q;
    assign mul_y      = mul_y_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign busy       = tag_any_s;

endmodule

// File: tb/tb_iddmm_mul_arbiter.sv
// Bench for iddmm_mul_arbiter: ideal pipelined multiplier model, a negedge
// monitor with an in-order scoreboard and round-robin model, an arbitration
// vector table, single-request product vectors, a reset-in-flight sequence
// and a random soak.
module tb_iddmm_mul_arbiter;

    localparam int W   = 128;
    localparam int N   = 4;
    localparam int L   = 7;
    localparam int LAT = L + 2;
    localparam int PW  = 2 * W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid, req_ready, req_lo, rsp_valid;
    logic [N*W-1:0]   req_x, req_y;
    logic [W-1:0]     mul_x, mul_y;
    logic [PW-1:0]    mul_result, rsp_result;
    logic             busy;

    always #5 clk = ~clk;

    iddmm_mul_arbiter #(.WIDTH(W), .NUM_REQ(N), .MUL_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_lo(req_lo), .req_x(req_x), .req_y(req_y), .mul_x(mul_x), .mul_y(mul_y),
        .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .busy(busy)
    );

    // Ideal multiplier: product of the operands seen in cycle C appears in C+L.
    logic [PW-1:0] mpipe [L];
    always @(posedge clk) begin
        mpipe[0] <= {{W{1'b0}}, mul_x} * {{W{1'b0}}, mul_y};
        for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_result = mpipe[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0, n_fail = 0;
    int hs_cnt = 0, rsp_cnt = 0, n_flushed = 0;
    bit mon_en = 1'b0;

    typedef struct { int id; logic [PW-1:0] res; int due; } sb_t;
    sb_t sb[$];

    typedef struct { logic [N-1:0] valid; logic [N-1:0] exp; } arb_t;
    typedef struct { int id; logic lo; logic [W-1:0] x; logic [W-1:0] y; logic [PW-1:0] exp; } vec_t;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] o;
        o = '0;
        o[id] = 1'b1;
        return o;
    endfunction

    function automatic logic [N-1:0] model_pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] g;
        g = '0;
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N] && g == '0) g[(p + k) % N] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [N*W-1:0] rnd_wide();
        logic [N*W-1:0] r;
        for (int k = 0; k < N*W/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks every cycle against the scoreboard and the arbitration
    // model, then records this cycle's handshake (or flushes on reset).
    int            tb_ptr = 0;
    logic [W-1:0]  tb_mx = '0, tb_my = '0;
    logic [PW-1:0] last_res = '0;
    always @(negedge clk) begin
        sb_t           e;
        logic [N-1:0]  eg;
        int            gid;
        logic [PW-1:0] p;
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rsp_valid", PW'(rsp_valid), PW'(onehot(e.id)));
                chk("rsp_result", rsp_result, e.res);
                last_res = e.res;
                rsp_cnt++;
            end else begin
                chk("rsp_valid_idle", PW'(rsp_valid), '0);
                chk("rsp_result_hold", rsp_result, last_res);
            end
            chk("busy", PW'(busy), PW'(sb.size() != 0));
            chk("mul_x", PW'(mul_x), PW'(tb_mx));
            chk("mul_y", PW'(mul_y), PW'(tb_my));
            eg = model_pick(req_valid, tb_ptr);
            chk("req_ready", PW'(req_ready), PW'(eg));
            if (!rst_n) begin
                n_flushed += sb.size();
                sb.delete();
                tb_ptr = 0; tb_mx = '0; tb_my = '0; last_res = '0;
            end else if (eg != '0) begin
                gid = 0;
                for (int k = 0; k < N; k++) if (eg[k]) gid = k;
                tb_mx = req_x[gid*W +: W];
                tb_my = req_y[gid*W +: W];
                p = {{W{1'b0}}, tb_mx} * {{W{1'b0}}, tb_my};
                if (req_lo[gid]) p[PW-1:W] = '0;
                sb.push_back('{id: gid, res: p, due: cyc + LAT});
                tb_ptr = (gid + 1) % N;
                hs_cnt++;
            end
        end
    end

    // One request alone; checks grant, the product W+... after LAT cycles and busy dropping.
    task automatic single(input vec_t v, input string nm);
        int t0;
        tick();
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        req_lo[v.id] = v.lo;
        req_x[v.id*W +: W] = v.x;
        req_y[v.id*W +: W] = v.y;
        t0 = cyc;
        @(negedge clk);
        chk({nm, "_grant"}, PW'(req_ready), PW'(onehot(v.id)));
        tick();
        req_valid = '0;
        req_lo = N'($urandom);
        req_x = rnd_wide();
        req_y = rnd_wide();
        while (cyc < t0 + LAT) tick();
        @(negedge clk);
        chk({nm, "_rsp_valid"}, PW'(rsp_valid), PW'(onehot(v.id)));
        chk({nm, "_rsp_result"}, rsp_result, v.exp);
        chk({nm, "_busy_after"}, PW'(busy), '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    arb_t arb [15];
    vec_t vec [5];

    initial begin
        int base;
        int guard;
        // Arbitration table from pointer 0: four rounds, then wrap cases.
        for (int i = 0; i < 8; i++) arb[i] = '{4'b1111, onehot(i % 4)};
        arb[8]  = '{4'b0100, 4'b0100};   // after grant 3, only 2 valid -> 2
        arb[9]  = '{4'b1100, 4'b1000};   // ptr 3 -> 3
        arb[10] = '{4'b0000, 4'b0000};
        arb[11] = '{4'b0110, 4'b0010};   // ptr 0 -> 1
        arb[12] = '{4'b0011, 4'b0001};   // ptr 2 wraps to 0
        arb[13] = '{4'b1010, 4'b0010};   // ptr 1 -> 1
        arb[14] = '{4'b1010, 4'b1000};   // ptr 2 -> 3

        vec[0] = '{0, 1'b0, 128'd3, 128'd5, 256'd15};
        vec[1] = '{1, 1'b0, {W{1'b1}}, {W{1'b1}}, {{(W-1){1'b1}}, 1'b0, {(W-1){1'b0}}, 1'b1}};
        vec[2] = '{1, 1'b1, {W{1'b1}}, {W{1'b1}}, 256'd1};
        vec[3] = '{2, 1'b1, 128'h1_0000_0000_0000_0003, 128'h1_0000_0000_0000_0005,
                   256'h0000_0000_0000_0008_0000_0000_0000_000F};
        vec[4] = '{3, 1'b0, 128'h1_0000_0000_0000_0003, 128'h1_0000_0000_0000_0005,
                   256'h1_0000_0000_0000_0008_0000_0000_0000_000F};

        req_valid = '0; req_lo = '0; req_x = '0; req_y = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        @(negedge clk);
        chk("reset_mul_x", PW'(mul_x), '0);
        chk("reset_mul_y", PW'(mul_y), '0);
        chk("reset_rsp_valid", PW'(rsp_valid), '0);
        chk("reset_rsp_result", rsp_result, '0);
        chk("reset_busy", PW'(busy), '0);

        for (int i = 0; i < 15; i++) begin
            tick();
            req_valid = arb[i].valid;
            req_lo = N'($urandom);
            req_x = rnd_wide();
            req_y = rnd_wide();
            @(negedge clk);
            chk($sformatf("arb_vec%0d", i), PW'(req_ready), PW'(arb[i].exp));
        end
        tick();
        req_valid = '0;
        repeat (LAT + 3) tick();

        for (int i = 0; i < 5; i++) single(vec[i], $sformatf("single%0d", i));

        // Three requests in flight, then a one-cycle reset.
        for (int i = 0; i < 3; i++) begin
            tick();
            req_valid = onehot(i);
            req_x = rnd_wide();
            req_y = rnd_wide();
        end
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("rstfl_rsp_valid%0d", i), PW'(rsp_valid), '0);
            chk($sformatf("rstfl_busy%0d", i), PW'(busy), '0);
            chk($sformatf("rstfl_mul_x%0d", i), PW'(mul_x), '0);
            chk($sformatf("rstfl_mul_y%0d", i), PW'(mul_y), '0);
            tick();
        end
        req_valid = 4'b1111;
        @(negedge clk);
        chk("post_reset_first_grant", PW'(req_ready), PW'(4'b0001));
        tick();
        req_valid = '0;
        single('{1, 1'b0, 128'd7, 128'd9, 256'd63}, "post_reset_req1");

        // Random soak until 1000 more accepts.
        base = hs_cnt;
        guard = 0;
        while (hs_cnt < base + 1000 && guard < 20000) begin
            tick();
            req_valid = N'($urandom_range(0, 15));
            req_lo = N'($urandom);
            req_x = rnd_wide();
            req_y = rnd_wide();
            guard++;
        end
        chk("rand_accepts_reached", PW'(hs_cnt - base >= 1000), PW'(1));
        tick();
        req_valid = '0;
        repeat (LAT + 3) tick();
        chk("sb_drained", PW'(sb.size()), '0);
        chk("rsp_count", PW'(rsp_cnt + n_flushed), PW'(hs_cnt));
        chk("final_busy", PW'(busy), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
